// File: rtl/cla_seq_alu_pkg.sv
// Shared constants for the group-serial CLA ALU: op encodings, FSM states, group width.
package cla_seq_alu_pkg;

  localparam int CLA_GROUP = 4;

  // op[2] is binv (also carry-in of bit 0); op[1:0] selects the function.
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] FN_AND = 2'b00;
  localparam logic [1:0] FN_OR  = 2'b01;
  localparam logic [1:0] FN_SUM = 2'b10;
  localparam logic [1:0] FN_SLT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_seq_alu_group4.sv
// 4-bit carry-lookahead group: per-bit generate/propagate, lookahead carries and sums.
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,     // already inverted when binv is set
  input  logic       cin,
  output logic [3:0] sum,
  output logic [3:0] g,
  output logic [3:0] p,
  output logic [4:0] c      // c[0]=cin, c[4]=group carry-out
);

  // Propagate is the OR form; it is valid for carries because g covers the both-ones case.
  assign g = a & b;
  assign p = a | b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  // With OR-form propagate the sum must use the true half-sum a^b.
  assign sum = a ^ b ^ c[3:0];

endmodule

// File: rtl/cla_seq_alu.sv
// Group-serial 32-bit ALU: one 4-bit CLA group per cycle, SLT resolved at the MSB.
module cla_seq_alu
  import cla_seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = CLA_GROUP   // fixed at 4 to match cla_group4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NGRP  = WIDTH / GROUP;
  localparam int IDX_W = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NGRP - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;          // stored already inverted for SUB/SLT
  logic [1:0]         fn_q, fn_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   acc_q, acc_d;      // partial result, filled one group per cycle
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [GROUP-1:0]   grp_a, grp_b, grp_sum, grp_g, grp_p, grp_res;
  logic [GROUP:0]     grp_c;
  logic [WIDTH-1:0]   merged, final_res;
  logic               arith, ovf_f, cout_f;
  logic               unused_carries;

  assign grp_a = a_q[int'(idx_q) * GROUP +: GROUP];
  assign grp_b = b_q[int'(idx_q) * GROUP +: GROUP];

  cla_group4 u_grp (
    .a   (grp_a),
    .b   (grp_b),
    .cin (carry_q),
    .sum (grp_sum),
    .g   (grp_g),
    .p   (grp_p),
    .c   (grp_c)
  );

  // Internal carries below the MSB are consumed inside the group only.
  assign unused_carries = ^grp_c[GROUP-2:0];

  // Select this group's contribution and form the final result/flags for the last group.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    grp_res   = '0;
    merged    = acc_q;
    final_res = '0;
    arith     = fn_q[1];
    unique case (fn_q)
      FN_AND:  grp_res = grp_g;
      FN_OR:   grp_res = grp_p;
      FN_SUM:  grp_res = grp_sum;
      default: grp_res = '0;
    endcase
    merged[int'(idx_q) * GROUP +: GROUP] = grp_res;
    ovf_f  = arith & (grp_c[GROUP-1] ^ grp_c[GROUP]);
    cout_f = arith & grp_c[GROUP];
    if (fn_q == FN_SLT) begin
      final_res[0] = grp_sum[GROUP-1] ^ ovf_f;
    end else begin
      final_res = merged;
    end
  end

  // FSM next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    fn_d     = fn_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{op[2]}};
          fn_d    = op[1:0];
          carry_d = op[2];
          idx_d   = '0;
          acc_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = merged;
        carry_d = grp_c[GROUP];
        if (idx_q == LAST_IDX) begin
          idx_d    = '0;
          result_d = final_res;
          zero_d   = (final_res == '0);
          cout_d   = cout_f;
          ovf_d    = ovf_f;
          state_d  = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      fn_q     <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      fn_q     <= fn_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_cla_seq_alu.sv
// Directed bench for cla_seq_alu: vector table plus reset and backpressure sequences.
module tb_cla_seq_alu;
  import cla_seq_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero, carry_out, overflow;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs [16];

  always #5 clk = ~clk;

  cla_seq_alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present a request for one edge; the DUT is expected to be in IDLE.
  task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid, bounded.
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_flags(input string name, input vec_t v);
    check({name, ".result"},    result,    v.res);
    check({name, ".zero"},      32'(zero),      32'(v.z));
    check({name, ".carry_out"}, 32'(carry_out), 32'(v.c));
    check({name, ".overflow"},  32'(overflow),  32'(v.v));
  endtask

  initial begin
    int   cyc;
    vec_t bp;

    vecs[0]  = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{OP_SLT, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{OP_SLT, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{OP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{OP_ADD, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{OP_SUB, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{OP_SLT, 32'h0000_0003, 32'h0000_0005, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{OP_SLT, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{3'b011, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{3'b100, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0000, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{3'b101, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{OP_ADD, 32'h1234_5678, 32'h0FED_CBA8, 32'h2222_2220, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready",  32'(in_ready),  32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.result",    result,         32'd0);
    check("rst.zero",      32'(zero),      32'd0);
    check("rst.carry_out", 32'(carry_out), 32'd0);
    check("rst.overflow",  32'(overflow),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_out(cyc);
      check($sformatf("vec%0d.latency", i), 32'(cyc), 32'd8);
      check_flags($sformatf("vec%0d", i), vecs[i]);
      handshake();
      check($sformatf("vec%0d.idle", i), 32'(in_ready), 32'd1);
    end

    // Reset mid-RUN discards the request; next ADD sees no stale state
    send(OP_ADD, 32'd5, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.in_ready",  32'(in_ready),  32'd1);
    check("midrst.result",    result,         32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(OP_ADD, 32'd1, 32'd1);
    wait_out(cyc);
    check("postrst.latency", 32'(cyc), 32'd8);
    check_flags("postrst", '{OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0});
    handshake();

    // Backpressure: hold DONE with a competing request pending
    bp = '{OP_SUB, 32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 1'b0, 1'b1, 1'b0};
    send(bp.op, bp.a, bp.b);
    wait_out(cyc);
    check("bp.latency", 32'(cyc), 32'd8);
    op = OP_OR; a = 32'h0000_00F0; b = 32'h0000_000F; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp.hold%0d.out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp.hold%0d.in_ready", k),  32'(in_ready),  32'd0);
      check_flags($sformatf("bp.hold%0d", k), bp);
    end
    handshake();
    check("bp.after_hs.in_ready",  32'(in_ready),  32'd1);
    check("bp.after_hs.out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp.accepted.in_ready", 32'(in_ready), 32'd0);
    wait_out(cyc);
    check("bp2.latency", 32'(cyc), 32'd8);
    check_flags("bp2", '{OP_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 1'b0});
    handshake();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
